// File: rtl/seq_add_pkg.sv
// -----------------------------------------------------------------------------
// seq_add_pkg
// Shared definitions for the byte-serial adder:
//   state_t   - controller states (IDLE, ADD, DONE)
//   BYTE_W    - width of one operand slice processed per ADD cycle
//   cnt_width - byte counter width for a given byte count (never below 1)
// -----------------------------------------------------------------------------
package seq_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-byte adder still needs a 1-bit counter so the index stays legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_add_rca8_if.sv
// -----------------------------------------------------------------------------
// seq_add_rca8_if
// Operand/result handshake bundle for seq_add_rca8.
//   in_valid  : producer offers operand pair a/b
//   in_ready  : adder accepts operands this cycle
//   a, b      : unsigned operands, NBYTES*8 bits
//   out_valid : sum holds a completed result
//   out_ready : consumer takes the result this cycle
//   sum       : unsigned a+b, final carry at the MSB (NBYTES*8+1 bits)
// master = operand producer / result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface seq_add_rca8_if #(
  parameter int NBYTES = 4
);
  import seq_add_pkg::*;

  localparam int W = BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum
  );

endinterface

// File: rtl/rca8_cin.sv
// -----------------------------------------------------------------------------
// rca8_cin
// Purely combinational 8-bit ripple-carry adder with carry-in.
//   a, b : 8-bit addends
//   cin  : carry into the bit-0 full adder
//   sum  : 8-bit result
//   cout : carry out of bit 7
// -----------------------------------------------------------------------------
module rca8_cin
  import seq_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic c;

  // Carry ripples bit by bit; each iteration is one full-adder cell.
  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_add_rca8.sv
// -----------------------------------------------------------------------------
// seq_add_rca8
// Byte-serial unsigned adder. An accepted operand pair is summed one byte per
// cycle through a single 8-bit ripple adder, least significant byte first,
// with the carry held in a register between bytes. The result is presented
// NBYTES cycles after acceptance and held until the consumer takes it.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (aborts any operation in flight)
//   bus : seq_add_rca8_if slave (in_valid/in_ready/a/b, out_valid/out_ready/sum)
// Parameter NBYTES: operand width in bytes, 1..16.
// -----------------------------------------------------------------------------
module seq_add_rca8
  import seq_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_add_rca8_if.slave bus
);

  localparam int              W    = BYTE_W * NBYTES;
  localparam int              CW   = cnt_width(NBYTES);
  localparam logic [CW-1:0]   LAST = CW'(NBYTES - 1);

  state_t              state;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W:0]          sum_q;
  logic                carry_q;
  logic [CW-1:0]       cnt_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [BYTE_W-1:0]   byte_a;
  logic [BYTE_W-1:0]   byte_b;
  logic [BYTE_W-1:0]   byte_s;
  logic                byte_co;
  logic                accept;

  assign byte_a = a_q[cnt_q*BYTE_W +: BYTE_W];
  assign byte_b = b_q[cnt_q*BYTE_W +: BYTE_W];

  rca8_cin u_rca (
    .a    (byte_a),
    .b    (byte_b),
    .cin  (carry_q),
    .sum  (byte_s),
    .cout (byte_co)
  );

  // in_ready_q is already 1 on the reset edge; masking with rst keeps the
  // port low while reset is held and high the first cycle after release.
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= ADD;
          end
        end

        ADD: begin
          sum_q[cnt_q*BYTE_W +: BYTE_W] <= byte_s;
          carry_q                       <= byte_co;
          if (cnt_q == LAST) begin
            // Counter is held on the last byte so it never wraps.
            sum_q[W]    <= byte_co;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_rca8.sv
// -----------------------------------------------------------------------------
// tb_seq_add_rca8
// Bench for seq_add_rca8 with a 4-byte and a 1-byte instance sharing clk/rst.
// Expected sums are computed from the driven operands and queued at accept;
// they are popped and compared when the adder presents its result.
// -----------------------------------------------------------------------------
module tb_seq_add_rca8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] sb4[$];
  logic [8:0]  sb1[$];

  seq_add_rca8_if #(.NBYTES(4)) i4 ();
  seq_add_rca8_if #(.NBYTES(1)) i1 ();

  seq_add_rca8 #(.NBYTES(4)) d4 (.clk(clk), .rst(rst), .bus(i4));
  seq_add_rca8 #(.NBYTES(1)) d1 (.clk(clk), .rst(rst), .bus(i1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair to the 4-byte adder; queue the expected sum at accept.
  task automatic accept4(input logic [31:0] av, input logic [31:0] bv, output bit ok);
    ok = 1'b0;
    i4.a = av;
    i4.b = bv;
    i4.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (i4.in_ready === 1'b1) begin
        sb4.push_back({1'b0, av} + {1'b0, bv});
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    i4.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_done4(output int lat);
    lat = 0;
    while (i4.out_valid !== 1'b1) begin
      if (lat >= 40) begin
        lat = -1;
        return;
      end
      step();
      lat++;
    end
  endtask

  task automatic release4();
    i4.out_ready = 1'b1;
    step();
    i4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (i4.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", i4.in_ready);
    end
    n_tests++;
    if (i4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", i4.out_valid);
    end
    n_tests++;
    if (i4.sum !== 33'h0) begin
      n_fail++; $display("FAIL reset_sum: got %h want 0", i4.sum);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (i4.in_ready !== 1'b1 || i1.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready: got %b/%b want 1/1", i4.in_ready, i1.in_ready);
    end
  endtask

  task automatic test_carry_chain();
    bit ok;
    int lat;
    logic [32:0] exp;
    accept4(32'hFFFF_FFFF, 32'h0000_0001, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL carry_accept: got no accept want accept");
    end
    wait_done4(lat);
    n_tests++;
    if (lat != 4) begin
      n_fail++; $display("FAIL carry_latency: got %0d want 4", lat);
    end
    exp = sb4.pop_front();
    n_tests++;
    if (i4.sum !== exp) begin
      n_fail++; $display("FAIL carry_sum: got %h want %h", i4.sum, exp);
    end
    release4();
    n_tests++;
    if (i4.out_valid !== 1'b0 || i4.in_ready !== 1'b1 || i4.sum !== exp) begin
      n_fail++;
      $display("FAIL carry_release: got ov=%b ir=%b sum=%h want ov=0 ir=1 sum=%h",
               i4.out_valid, i4.in_ready, i4.sum, exp);
    end
  endtask

  task automatic test_values();
    logic [31:0] ta[2];
    logic [31:0] tb[2];
    bit ok;
    int lat;
    logic [32:0] exp;
    ta[0] = 32'h1234_5678; tb[0] = 32'h1111_1111;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      accept4(ta[i], tb[i], ok);
      // out_ready asserted during ADD must have no effect.
      i4.out_ready = 1'b1;
      wait_done4(lat);
      n_tests++;
      if (!ok || lat != 4) begin
        n_fail++; $display("FAIL values_latency[%0d]: got ok=%b lat=%0d want ok=1 lat=4", i, ok, lat);
      end
      exp = sb4.pop_front();
      n_tests++;
      if (i4.sum !== exp) begin
        n_fail++; $display("FAIL values_sum[%0d]: got %h want %h", i, i4.sum, exp);
      end
      step();
      i4.out_ready = 1'b0;
      n_tests++;
      if (i4.out_valid !== 1'b0 || i4.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL values_return[%0d]: got ov=%b ir=%b want 0/1", i, i4.out_valid, i4.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [32:0] exp;
    accept4(32'h0F0F_0F0F, 32'h0101_0101, ok);
    wait_done4(lat);
    exp = sb4[0];
    i4.in_valid = 1'b1;
    i4.a = 32'hDEAD_BEEF;
    i4.b = 32'hCAFE_F00D;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (i4.out_valid !== 1'b1 || i4.in_ready !== 1'b0 || i4.sum !== exp) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b ir=%b sum=%h want ov=1 ir=0 sum=%h",
                 c, i4.out_valid, i4.in_ready, i4.sum, exp);
      end
    end
    i4.in_valid = 1'b0;
    void'(sb4.pop_front());
    release4();
    n_tests++;
    if (i4.out_valid !== 1'b0 || i4.in_ready !== 1'b1 || i4.sum !== exp) begin
      n_fail++;
      $display("FAIL backpressure_release: got ov=%b ir=%b sum=%h want ov=0 ir=1 sum=%h",
               i4.out_valid, i4.in_ready, i4.sum, exp);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    int seen;
    logic [32:0] exp;
    accept4(32'h1111_1111, 32'h2222_2222, ok);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    sb4.delete();
    n_tests++;
    if (i4.out_valid !== 1'b0 || i4.sum !== 33'h0 || i4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_state: got ov=%b sum=%h ir=%b want ov=0 sum=0 ir=1",
               i4.out_valid, i4.sum, i4.in_ready);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (i4.out_valid === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_mid_no_pulse: got %0d out_valid cycles want 0", seen);
    end
    accept4(32'h0000_0080, 32'h0000_0080, ok);
    wait_done4(lat);
    exp = sb4.pop_front();
    n_tests++;
    if (lat != 4 || i4.sum !== exp) begin
      n_fail++; $display("FAIL reset_mid_next: got lat=%0d sum=%h want lat=4 sum=%h", lat, i4.sum, exp);
    end
    release4();
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int acc = 0;
    int got = 0;
    logic [32:0] exp;
    i4.out_ready = 1'b1;
    i4.in_valid  = 1'b1;
    i4.a = $urandom;
    i4.b = $urandom;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (i4.out_valid === 1'b1) begin
        n_tests++;
        if (sb4.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected: got result %h want none", i4.sum);
        end else begin
          exp = sb4.pop_front();
          got++;
          if (i4.sum !== exp) begin
            n_fail++; $display("FAIL b2b_sum: got %h want %h", i4.sum, exp);
          end
        end
      end
      if (i4.in_ready === 1'b1) begin
        sb4.push_back({1'b0, i4.a} + {1'b0, i4.b});
        if (last >= 0) begin
          n_tests++;
          if (cyc - last != 6) begin
            n_fail++; $display("FAIL b2b_interval: got %0d want 6", cyc - last);
          end
        end
        last = cyc;
        acc++;
      end
      step();
      i4.a = $urandom;
      i4.b = $urandom;
    end
    i4.in_valid = 1'b0;
    for (int c = 0; c < 20 && sb4.size() > 0; c++) begin
      if (i4.out_valid === 1'b1) begin
        exp = sb4.pop_front();
        got++;
        n_tests++;
        if (i4.sum !== exp) begin
          n_fail++; $display("FAIL b2b_drain_sum: got %h want %h", i4.sum, exp);
        end
      end
      step();
    end
    i4.out_ready = 1'b0;
    n_tests++;
    if (acc < 10 || got != acc) begin
      n_fail++; $display("FAIL b2b_count: got accepts=%0d results=%0d want >=10 equal", acc, got);
    end
  endtask

  task automatic test_single_byte();
    int lat;
    logic [8:0] exp;
    i1.a = 8'hFF;
    i1.b = 8'h01;
    i1.in_valid = 1'b1;
    n_tests++;
    if (i1.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL nb1_ready: got %b want 1", i1.in_ready);
    end
    sb1.push_back({1'b0, i1.a} + {1'b0, i1.b});
    step();
    i1.in_valid = 1'b0;
    lat = 0;
    while (i1.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    n_tests++;
    if (lat != 0 && lat != 1) begin
      n_fail++; $display("FAIL nb1_latency: got %0d want 1", lat);
    end else if (lat == 0) begin
      n_fail++; $display("FAIL nb1_latency: got 0 want 1");
    end
    exp = sb1.pop_front();
    n_tests++;
    if (i1.sum !== exp) begin
      n_fail++; $display("FAIL nb1_sum: got %h want %h", i1.sum, exp);
    end
    i1.out_ready = 1'b1;
    step();
    i1.out_ready = 1'b0;
    n_tests++;
    if (i1.out_valid !== 1'b0 || i1.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL nb1_return: got ov=%b ir=%b want 0/1", i1.out_valid, i1.in_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i4.in_valid = 1'b0; i4.a = '0; i4.b = '0; i4.out_ready = 1'b0;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.out_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_single_byte();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_add_rca8.md
SEQ_ADD_RCA8 -- requirements
Module: seq_add_rca8

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning the number of 8-bit operand bytes processed; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the operand pair on a/b is offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts operands this cycle.
REQ-006 SHALL have port a, input, 8*NBYTES, meaning the unsigned operand A.
REQ-007 SHALL have port b, input, 8*NBYTES, meaning the unsigned operand B.
REQ-008 SHALL have port out_valid, output, 1, meaning sum holds a completed result.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-010 SHALL have port sum, output, 8*NBYTES+1, meaning the unsigned A+B, with the final carry at the MSB.

Function
REQ-011 SHALL implement FSM states IDLE, ADD and DONE.
REQ-012 SHALL hold in_ready=1 only in IDLE, and out_valid=1 only in DONE; both are registered outputs.
REQ-013 SHALL accept operands on an edge where in_valid&in_ready, and on that edge:
- capture a and b into operand registers;
- clear the carry register;
- clear the byte counter;
- clear sum;
- move to ADD.
REQ-014 In ADD, SHALL on each edge:
- add byte[cnt] of A, byte[cnt] of B and the carry register through one 8-bit ripple adder with carry-in;
- write the 8-bit result to sum[8*cnt+7:8*cnt];
- write the carry-out to the carry register;
- increment cnt.
REQ-015 SHALL, on the ADD edge with cnt==NBYTES-1, also write the carry-out to sum[8*NBYTES] and move to DONE.
REQ-016 SHALL raise out_valid exactly NBYTES cycles after the acceptance edge; latency is fixed and independent of operand values.
REQ-017 SHALL hold DONE, with sum and out_valid stable, while out_ready=0 (backpressure of unbounded length).
REQ-018 SHALL return to IDLE on an edge where out_valid&out_ready, holding sum at its last value; out_valid returns to 0.
REQ-019 SHALL ignore in_valid and a/b outside IDLE, with no queuing. The minimum accept-to-accept interval is NBYTES+2 cycles.
REQ-020 SHALL ignore out_ready outside DONE.
REQ-021 SHALL produce a result equal to (A+B) mod 2^(8*NBYTES+1), with no overflow loss.
REQ-022 SHALL never let the byte counter wrap; cnt width is clog2(NBYTES) with a minimum of 1.

Reset
REQ-023 SHALL, on an edge with rst=1, force the following, regardless of state and with rst overriding all other inputs:
- state=IDLE;
- sum=0, carry=0, cnt=0, operand registers=0;
- out_valid=0.
REQ-024 SHALL drive in_ready=0 while rst=1, and in_ready=1 from the first cycle after rst deasserts.
REQ-025 SHALL, on reset asserted mid-ADD or mid-DONE, abort the operation and discard the partial result; no out_valid pulse follows.

Structure
REQ-026 SHALL place the FSM state enum and the byte width constant (8) in a shared package, seq_add_pkg.
REQ-027 SHALL use one combinational sub-module, rca8_cin: an 8-bit ripple-carry adder whose bit-0 cell is a full adder fed by cin, with outputs sum[7:0] and cout.

Verification
REQ-028 With NBYTES=4, accept a=0xFFFFFFFF, b=0x00000001 -> out_valid 4 cycles after accept, sum=0x1_00000000.
REQ-029 Accept a=0x12345678, b=0x11111111 -> sum=0x0_23456789; then a=0xFFFFFFFF, b=0xFFFFFFFF -> sum=0x1_FFFFFFFE.
REQ-030 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> sum stable, in_ready=0, new operands not captured.
REQ-031 Assert rst for 1 cycle at the second ADD edge -> next cycle out_valid=0, sum=0, in_ready=1; the following operation 0x00000080+0x00000080 -> sum=0x0_00000100.
REQ-032 With out_ready tied 1 and in_valid tied 1 with random operands, accepts occur every 6 cycles and every sum matches a reference model.
REQ-033 With NBYTES=1, accept a=0xFF, b=0x01 -> out_valid 1 cycle after accept, sum=0x100.
